// File: rtl/move_list_collector.sv
// Move-list collector: snapshots one square's 16 move words, scans them in two
// passes (captures first, quiet moves second) and queues non-empty moves in a
// FIFO that drains to the search controller through a valid/ready stream.
module move_list_collector #(
  parameter int unsigned NUM_SLOTS = 16,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned CW        = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    clear_n,
  input  logic                    start,
  input  logic                    flush,
  input  logic [NUM_SLOTS*32-1:0] moves_in,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [31:0]             move_out,
  output logic                    move_valid,
  input  logic                    move_ready,
  output logic [CW-1:0]           move_count
);

  localparam int unsigned WW = 32;
  localparam int unsigned IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SLOTS - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN1 = 2'd1,
    S_SCAN2 = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [NUM_SLOTS*WW-1:0] snap_q;
  logic [IW-1:0]           idx_q;
  logic                    overflow_q;
  logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           count_q, count_d;
  logic [WW-1:0]           mem_q [DEPTH];

  logic          idle_c, scan_c, cap_pass_c;
  logic [WW-1:0] cur_word_c;
  logic          push_c, pop_c, full_c, wr_en_c, drop_c, flush_c, go_c;

  // State register
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state: two full passes over the slots, then a one-cycle DONE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_SCAN1;
      S_SCAN1: if (idx_q == LAST_IDX) state_d = S_SCAN2;
      S_SCAN2: if (idx_q == LAST_IDX) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the state register
  always_comb begin
    idle_c     = 1'b0;
    scan_c     = 1'b0;
    cap_pass_c = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    unique case (state_q)
      S_IDLE:  begin idle_c = 1'b1; busy = 1'b0; end
      S_SCAN1: begin scan_c = 1'b1; cap_pass_c = 1'b1; end
      S_SCAN2: scan_c = 1'b1;
      S_DONE:  done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Select the snapshot slot under the scan index
  always_comb begin
    cur_word_c = '0;
    for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
      if (idx_q == IW'(k)) cur_word_c = snap_q[WW*k +: WW];
    end
  end

  // Push/pop arbitration; a pop in the same cycle frees room for a push into a full list
  always_comb begin
    go_c    = idle_c && start;
    flush_c = idle_c && flush;
    push_c  = scan_c && (cur_word_c != '0) &&
              ((cur_word_c[29:24] != 6'd0) == cap_pass_c);
    pop_c   = (count_q != '0) && move_ready;
    full_c  = (count_q == FULL_CNT);
    wr_en_c = push_c && (!full_c || pop_c);
    drop_c  = push_c && full_c && !pop_c;
    count_d = count_q;
    if (wr_en_c && !pop_c)      count_d = count_q + CW'(1);
    else if (!wr_en_c && pop_c) count_d = count_q - CW'(1);
  end

  // Snapshot, scan index and sticky overflow
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      snap_q     <= '0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (go_c) begin
        snap_q     <= moves_in;
        idx_q      <= '0;
        overflow_q <= 1'b0;
      end else begin
        if (scan_c) idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
        if (drop_c) overflow_q <= 1'b1;
      end
    end
  end

  // FIFO pointers and occupancy; flush wins over a same-cycle pop
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_c) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en_c) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_c)   rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  // FIFO storage; contents are only observable while counted
  always_ff @(posedge clk) begin
    if (wr_en_c) mem_q[wr_ptr_q] <= cur_word_c;
  end

  assign overflow   = overflow_q;
  assign move_valid = (count_q != '0);
  assign move_out   = move_valid ? mem_q[rd_ptr_q] : '0;
  assign move_count = count_q;

endmodule
